// File: rtl/serv_rf_ram_banked.sv
// Banked SERV register file on 256x8 single-port SRAM macros with a one-entry write buffer.
// Ports: i_clk, i_rst_n, write (i_waddr/i_wdata/i_wen/o_wready), read (i_raddr/i_ren/o_rdata/o_rvalid).

module serv_rf_ram_macro #(
  parameter int aw = 8
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          gwen,
  input  logic [7:0]    wen,
  input  logic [aw-1:0] a,
  input  logic [7:0]    d,
  output logic [7:0]    q
);
  logic [7:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) mem[a] <= (d & ~wen) | (mem[a] & wen);
      else       q      <= mem[a];
    end
  end
endmodule

module serv_rf_ram_banked #(
  parameter int width       = 8,
  parameter int csr_regs    = 4,
  parameter int depth       = 32*(32+csr_regs)/width,
  parameter int macro_depth = 256,
  localparam int aw         = $clog2(depth)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  output logic             o_wready,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_rvalid
);
  localparam int lanes  = width/8;
  localparam int nbanks = (depth+macro_depth-1)/macro_depth;
  localparam int mw     = $clog2(macro_depth);
  localparam int bw     = nbanks > 1 ? $clog2(nbanks) : 1;
  localparam int rlo    = 5-$clog2(width);

  function automatic logic [bw-1:0] bank_of(logic [aw-1:0] x);
    return bw'(int'(x) / macro_depth);
  endfunction

  function automatic logic [mw-1:0] off_of(logic [aw-1:0] x);
    return mw'(int'(x) % macro_depth);
  endfunction

  function automatic logic in_range(logic [aw-1:0] x);
    return int'(x) < depth;
  endfunction

  logic             buf_valid;
  logic [aw-1:0]    buf_addr;
  logic [width-1:0] buf_data;

  logic             rd_zero;
  logic             rd_byp;
  logic [bw-1:0]    rd_bank;
  logic [width-1:0] byp_data;
  logic [width-1:0] rdata_q;

  logic             act;
  logic             we;
  logic [bw-1:0]    sbank;
  logic [mw-1:0]    sa;
  logic [width-1:0] sd;

  logic             w_ok;
  logic [7:0]       q [nbanks][lanes];
  logic [width-1:0] q_bank;
  logic [width-1:0] rd_mux;

  assign o_wready = !(buf_valid && i_ren);
  // Out-of-range writes are accepted but never reach buffer or SRAM.
  assign w_ok     = i_wen && in_range(i_waddr);

  // Single SRAM port: read first, then buffer drain, then direct write.
  always_comb begin
    act   = 1'b0;
    we    = 1'b0;
    sbank = bank_of(i_raddr);
    sa    = off_of(i_raddr);
    sd    = buf_data;
    if (i_ren) begin
      act = in_range(i_raddr);
    end else if (buf_valid) begin
      act   = 1'b1;
      we    = 1'b1;
      sbank = bank_of(buf_addr);
      sa    = off_of(buf_addr);
    end else if (w_ok) begin
      act   = 1'b1;
      we    = 1'b1;
      sbank = bank_of(i_waddr);
      sa    = off_of(i_waddr);
      sd    = i_wdata;
    end
  end

  for (genvar b = 0; b < nbanks; b++) begin : g_bank
    logic cen;
    assign cen = !(act && sbank == bw'(b));
    for (genvar l = 0; l < lanes; l++) begin : g_lane
      serv_rf_ram_macro #(.aw(mw)) u_macro (
        .clk  (i_clk),
        .cen  (cen),
        .gwen (!we),
        .wen  ({8{!we}}),
        .a    (sa),
        .d    (sd[8*l +: 8]),
        .q    (q[b][l])
      );
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (i_ren) begin
      // Read owns the port; an empty buffer absorbs the write.
      if (!buf_valid && w_ok) begin
        buf_valid <= 1'b1;
        buf_addr  <= i_waddr;
        buf_data  <= i_wdata;
      end
    end else if (buf_valid) begin
      buf_valid <= w_ok;
      if (w_ok) begin
        buf_addr <= i_waddr;
        buf_data <= i_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rvalid <= 1'b0;
      rd_zero  <= 1'b0;
      rd_byp   <= 1'b0;
      rd_bank  <= '0;
      byp_data <= '0;
      rdata_q  <= '0;
    end else begin
      o_rvalid <= i_ren;
      if (i_ren) begin
        rd_zero  <= !in_range(i_raddr) || i_raddr[aw-1:rlo] == '0;
        rd_byp   <= buf_valid && buf_addr == i_raddr;
        rd_bank  <= bank_of(i_raddr);
        byp_data <= buf_data;
      end
      if (o_rvalid) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    q_bank = '0;
    for (int b = 0; b < nbanks; b++) begin
      if (rd_bank == bw'(b)) begin
        for (int l = 0; l < lanes; l++) q_bank[8*l +: 8] = q[b][l];
      end
    end
  end

  assign rd_mux  = rd_zero ? '0 : rd_byp ? byp_data : q_bank;
  assign o_rdata = o_rvalid ? rd_mux : rdata_q;
endmodule
